enc_histogram: RTL and testbench
================================

// Module: enc_histogram
// PURPOSE
//   Downstream consumer of the 8->3 bit-position encoder. Each valid 3-bit
//   index from the encoder increments one of 8 bins over a sample window of
//   WINDOW samples; the block then freezes and flags done. Software/bench
//   reads bins through a 1-cycle registered read port. Sync clr restarts.
// PARAMETERS
//   CNT_W   8    bin counter width; bins saturate at 2**CNT_W-1
//   WINDOW  16   samples per window; 0 = unlimited (never DONE)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      in_index valid this cycle
//   in_index   in   3      encoder result (bin select)
//   clr        in   1      sync clear: zero bins/total, return to COUNT
//   rd_en      in   1      read request
//   rd_addr    in   3      bin to read
//   rd_data    out  CNT_W  bin value, valid when rd_valid
//   rd_valid   out  1      pulses 1 cycle after rd_en
//   total      out  TW     samples accepted, TW=$clog2(WINDOW+1) (min 1; 16 if WINDOW=0)
//   done       out  1      high in DONE state
//   peak_idx   out  3      see CONFIGURATION
//   peak_cnt   out  CNT_W  see CONFIGURATION
// BEHAVIOUR
//   - Reset (async): all bins=0, total=0, state=COUNT, done=0, rd_data=0,
//     rd_valid=0, peak_idx=0, peak_cnt=0.
//   - FSM: COUNT -> DONE when an accepted sample makes total==WINDOW
//     (WINDOW!=0). DONE -> COUNT only on clr. done registered = (state==DONE),
//     so done rises the cycle after the last sample's edge.
//   - Accept: in_valid && state==COUNT && !clr. bin[in_index] += 1 unless
//     already 2**CNT_W-1 (saturate, hold). total += 1 on every accept; if
//     WINDOW=0, total wraps modulo 2**TW and never DONE.
//   - In DONE, in_valid ignored; bins and total hold.
//   - clr beats in_valid same cycle: sample dropped, all counts 0 next cycle.
//   - Read: rd_en at edge N -> rd_data=bin[rd_addr], rd_valid=1 after edge N,
//     both held until next edge. rd_data holds last value while rd_valid=0.
//     Read colliding with an update of the same bin returns the pre-update
//     value. Read colliding with clr returns the pre-clear value.
//   - Reads are legal in any state, do not disturb counts.
//   - rst mid-window: immediate return to reset values, no partial state kept.
// CONFIGURATION
//   HIST_PEAK_EN defined: peak_idx/peak_cnt registered from the current bins
//     (one cycle behind bin updates); peak = largest bin, ties -> lowest index;
//     all-zero bins -> peak_idx=0, peak_cnt=0. Cleared by clr like bins.
//   HIST_PEAK_EN undefined: no peak logic; peak_idx=0, peak_cnt=0 constantly.
// TESTING
//   1 Reset: rst=1 mid-run -> all outputs 0 asynchronously; after release,
//     read bin 0..7 -> rd_data=0, rd_valid 1 cycle after each rd_en.
//   2 Window fill: WINDOW=16, feed index 7 x10, index 2 x6 -> total=16,
//     done=1 next cycle; bin7=10, bin2=6; 3 further samples ignored (total=16).
//   3 Saturation: CNT_W=3, WINDOW=0, feed index 5 x9 -> bin5=7 held,
//     total=9; other bins 0.
//   4 Collisions: clr with in_valid -> counts 0, sample dropped; rd_en on
//     bin3=4 with in_index=3 same cycle -> rd_data=4, later read gives 5.
//   5 clr from DONE: done=1, pulse clr -> done=0, total=0, new samples counted.
//   6 HIST_PEAK_EN: feed 1,4,4,1 -> peak_idx=1, peak_cnt=2 (tie, lowest);
//     add 4 -> peak_idx=4, peak_cnt=3 one cycle after bin update; without
//     macro peak_idx=0, peak_cnt=0 throughout.

Source files
------------

// File: rtl/enc_histogram.sv
// 8-bin histogram of encoder indices over a WINDOW-sample window (WINDOW=0: free-running), 1-cycle registered read port.
// Optional macro HIST_PEAK_EN adds a registered largest-bin tracker (ties resolve to the lowest index).
module enc_histogram #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16,
  localparam int TW = (WINDOW == 0) ? 16 : ((WINDOW == 1) ? 1 : $clog2(WINDOW + 1))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       in_index,
  input  logic             clr,
  input  logic             rd_en,
  input  logic [2:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [TW-1:0]    total,
  output logic             done,
  output logic [2:0]       peak_idx,
  output logic [CNT_W-1:0] peak_cnt
);

  typedef enum logic {S_COUNT, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TW-1:0]    WIN_T   = TW'(WINDOW);

  state_t           state_q, state_d;
  logic [TW-1:0]    total_q, total_d;
  logic [CNT_W-1:0] bins_q [8];
  logic [CNT_W-1:0] bins_d [8];
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             accept;

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    bins_d     = bins_q;
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    accept     = in_valid && (state_q == S_COUNT) && !clr;

    // Read samples the pre-update bins, so collisions with updates or clr return old data.
    if (rd_en) begin
      rd_data_d = bins_q[rd_addr];
    end

    if (clr) begin
      state_d = S_COUNT;
      total_d = '0;
      for (int i = 0; i < 8; i++) begin
        bins_d[i] = '0;
      end
    end else if (accept) begin
      if (bins_q[in_index] != CNT_MAX) begin
        bins_d[in_index] = bins_q[in_index] + 1'b1;
      end
      total_d = total_q + 1'b1;
      if ((WINDOW != 0) && (total_d == WIN_T)) begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_COUNT;
      total_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        bins_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      bins_q     <= bins_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign total    = total_q;
  assign done     = (state_q == S_DONE);

`ifdef HIST_PEAK_EN
  logic [2:0]       peak_idx_q, peak_idx_d;
  logic [CNT_W-1:0] peak_cnt_q, peak_cnt_d;

  // Strict greater-than keeps the first (lowest) index on ties.
  always_comb begin
    peak_idx_d = '0;
    peak_cnt_d = '0;
    for (int i = 0; i < 8; i++) begin
      if (bins_q[i] > peak_cnt_d) begin
        peak_cnt_d = bins_q[i];
        peak_idx_d = 3'(i);
      end
    end
    if (clr) begin
      peak_idx_d = '0;
      peak_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_idx_q <= '0;
      peak_cnt_q <= '0;
    end else begin
      peak_idx_q <= peak_idx_d;
      peak_cnt_q <= peak_cnt_d;
    end
  end

  assign peak_idx = peak_idx_q;
  assign peak_cnt = peak_cnt_q;
`else
  assign peak_idx = '0;
  assign peak_cnt = '0;
`endif

endmodule

// File: tb/tb_enc_histogram.sv
// Bench for enc_histogram: default instance (CNT_W=8, WINDOW=16) and a saturating one (CNT_W=3, WINDOW=0)
// share stimulus; both are compared every cycle against a simple array model.
module tb_enc_histogram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_index = '0;
  logic       clr = 1'b0;
  logic       rd_en = 1'b0;
  logic [2:0] rd_addr = '0;

  logic [7:0]  a_rd_data;
  logic        a_rd_valid;
  logic [4:0]  a_total;
  logic        a_done;
  logic [2:0]  a_peak_idx;
  logic [7:0]  a_peak_cnt;

  logic [2:0]  b_rd_data;
  logic        b_rd_valid;
  logic [15:0] b_total;
  logic        b_done;
  logic [2:0]  b_peak_idx;
  logic [2:0]  b_peak_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // model state, index 0 = default instance, 1 = saturating instance
  int m_bin [2][8];
  int m_total [2];
  int m_done [2];
  int m_rd [2];
  int m_rdv;
  int m_pi [2];
  int m_pc [2];

  always #5 clk = ~clk;

  enc_histogram u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_index(in_index), .clr(clr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .total(a_total), .done(a_done), .peak_idx(a_peak_idx), .peak_cnt(a_peak_cnt)
  );

  enc_histogram #(.CNT_W(3), .WINDOW(0)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_index(in_index), .clr(clr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .total(b_total), .done(b_done), .peak_idx(b_peak_idx), .peak_cnt(b_peak_cnt)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bin_max(input int k);
    return (k == 0) ? 255 : 7;
  endfunction

  function automatic int total_mod(input int k);
    return (k == 0) ? 32 : 65536;
  endfunction

  function automatic int win(input int k);
    return (k == 0) ? 16 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 8; b++) m_bin[k][b] = 0;
      m_total[k] = 0;
      m_done[k]  = 0;
      m_rd[k]    = 0;
      m_pi[k]    = 0;
      m_pc[k]    = 0;
    end
    m_rdv = 0;
  endtask

  // advance the model across one rising edge using the currently driven inputs
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int mx;
      int pi;
      mx = 0;
      foreach (m_bin[k][b]) if (m_bin[k][b] > mx) mx = m_bin[k][b];
      pi = 0;
      for (int b = 7; b >= 0; b--) if (m_bin[k][b] == mx) pi = b;
      m_pi[k] = clr ? 0 : pi;
      m_pc[k] = clr ? 0 : mx;
      if (rd_en) m_rd[k] = m_bin[k][rd_addr];
      if (clr) begin
        for (int b = 0; b < 8; b++) m_bin[k][b] = 0;
        m_total[k] = 0;
        m_done[k]  = 0;
      end else if (in_valid && !m_done[k]) begin
        if (m_bin[k][in_index] < bin_max(k)) m_bin[k][in_index]++;
        m_total[k] = (m_total[k] + 1) % total_mod(k);
        if (win(k) != 0 && m_total[k] == win(k)) m_done[k] = 1;
      end
    end
    m_rdv = rd_en ? 1 : 0;
  endtask

  task automatic compare_all();
    int ea_pi, ea_pc, eb_pi, eb_pc;
`ifdef HIST_PEAK_EN
    ea_pi = m_pi[0]; ea_pc = m_pc[0]; eb_pi = m_pi[1]; eb_pc = m_pc[1];
`else
    ea_pi = 0; ea_pc = 0; eb_pi = 0; eb_pc = 0;
`endif
    check_eq("a_rd_valid", int'(a_rd_valid), m_rdv);
    check_eq("a_rd_data",  int'(a_rd_data),  m_rd[0]);
    check_eq("a_total",    int'(a_total),    m_total[0]);
    check_eq("a_done",     int'(a_done),     m_done[0]);
    check_eq("a_peak_idx", int'(a_peak_idx), ea_pi);
    check_eq("a_peak_cnt", int'(a_peak_cnt), ea_pc);
    check_eq("b_rd_valid", int'(b_rd_valid), m_rdv);
    check_eq("b_rd_data",  int'(b_rd_data),  m_rd[1]);
    check_eq("b_total",    int'(b_total),    m_total[1]);
    check_eq("b_done",     int'(b_done),     m_done[1]);
    check_eq("b_peak_idx", int'(b_peak_idx), eb_pi);
    check_eq("b_peak_cnt", int'(b_peak_cnt), eb_pc);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic feed(input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_index = 3'(idx);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic rd(input int addr);
    rd_en   = 1'b1;
    rd_addr = 3'(addr);
    step();
    rd_en   = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check_eq("rst_total", int'(a_total), 0);
    rst = 1'b0;

    // asynchronous reset mid-run
    feed(0, 3);
    rd(0);
    check_eq("pre_rst_rd", int'(a_rd_data), 3);
    #3 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check_eq("async_rst_total", int'(a_total), 0);
    check_eq("async_rst_rd", int'(a_rd_data), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int b = 0; b < 8; b++) begin
      rd(b);
      check_eq("post_rst_rdv", int'(a_rd_valid), 1);
    end
    step();
    check_eq("rdv_drop", int'(a_rd_valid), 0);

    // window fill
    do_clr();
    feed(7, 10);
    feed(2, 6);
    check_eq("win_total", int'(a_total), 16);
    check_eq("win_done", int'(a_done), 1);
    feed(5, 3);
    check_eq("win_hold_total", int'(a_total), 16);
    rd(7);
    check_eq("win_bin7", int'(a_rd_data), 10);
    rd(2);
    check_eq("win_bin2", int'(a_rd_data), 6);

    // saturation on the narrow, unlimited instance
    do_clr();
    feed(5, 9);
    rd(5);
    check_eq("sat_bin5", int'(b_rd_data), 7);
    check_eq("sat_total", int'(b_total), 9);
    rd(4);
    check_eq("sat_bin4", int'(b_rd_data), 0);

    // collisions
    do_clr();
    feed(1, 2);
    in_valid = 1'b1; in_index = 3'd1; clr = 1'b1;
    step();
    in_valid = 1'b0; clr = 1'b0;
    check_eq("clr_in_total", int'(a_total), 0);
    feed(3, 4);
    rd_en = 1'b1; rd_addr = 3'd3; in_valid = 1'b1; in_index = 3'd3;
    step();
    rd_en = 1'b0; in_valid = 1'b0;
    check_eq("rd_upd_old", int'(a_rd_data), 4);
    rd(3);
    check_eq("rd_upd_new", int'(a_rd_data), 5);
    rd_en = 1'b1; rd_addr = 3'd3; clr = 1'b1;
    step();
    rd_en = 1'b0; clr = 1'b0;
    check_eq("rd_clr_old", int'(a_rd_data), 5);
    check_eq("rd_clr_total", int'(a_total), 0);

    // clr out of DONE
    for (int i = 0; i < 40 && !a_done; i++) feed($urandom_range(0, 7), 1);
    check_eq("reach_done", int'(a_done), 1);
    do_clr();
    check_eq("clr_done", int'(a_done), 0);
    check_eq("clr_done_total", int'(a_total), 0);
    feed(6, 1);
    check_eq("after_clr_total", int'(a_total), 1);

    // peak tracking
    do_clr();
    feed(1, 1); feed(4, 2); feed(1, 1);
    step();
`ifdef HIST_PEAK_EN
    check_eq("peak_tie_idx", int'(a_peak_idx), 1);
    check_eq("peak_tie_cnt", int'(a_peak_cnt), 2);
`endif
    feed(4, 1);
`ifdef HIST_PEAK_EN
    check_eq("peak_lag_idx", int'(a_peak_idx), 1);
`endif
    step();
`ifdef HIST_PEAK_EN
    check_eq("peak_new_idx", int'(a_peak_idx), 4);
    check_eq("peak_new_cnt", int'(a_peak_cnt), 3);
`else
    check_eq("peak_off_idx", int'(a_peak_idx), 0);
    check_eq("peak_off_cnt", int'(a_peak_cnt), 0);
`endif

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_index = 3'($urandom_range(0, 7));
      clr      = ($urandom_range(0, 40) == 0);
      rd_en    = 1'($urandom_range(0, 1));
      rd_addr  = 3'($urandom_range(0, 7));
      step();
    end
    in_valid = 1'b0; clr = 1'b0; rd_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
